// File: rtl/maxpool_frame_ctrl.sv
// maxpool_frame_ctrl
//   Frame sequencer around a 2x2 binary max-pool. Each pooled bit is the OR
//   of its 2x2 input window. The block collects one binary image, one row
//   per beat, and stores the whole frame. It runs a single pooling pass:
//   the pool is combinational and its result is captured in a register.
//   The pooled rows are then streamed out. Only one frame is in flight at a
//   time.
//
//   Parameters
//     IMG_IN_SIZE   input width/height in pixels (even, >= 2)
//     IMG_OUT_SIZE  derived: IMG_IN_SIZE/2
//     ROW_IDX_W     derived: $clog2(IMG_IN_SIZE), row counter width
//
//   Ports
//     clk, rst_n    rising-edge clock, asynchronous active-low reset
//     flush         synchronous abort of the current frame (highest priority)
//     in_valid/in_ready/in_row     input row stream, bit c = column c
//     out_valid/out_ready/out_row  pooled row stream, bit c = pooled column c
//     out_last      marks pooled row IMG_OUT_SIZE-1
//     busy          high while in LOAD, POOL or DRAIN
//     frame_done    one-cycle pulse after the last pooled row is accepted
//     frame_count   (only with MAXPOOL_FRAME_CNT_EN) completed-frame counter
//
//   Optional feature macro: MAXPOOL_FRAME_CNT_EN adds the frame_count port.
//
//   Handshake: a beat moves on a rising edge where valid && ready are both
//   high. The producer holds valid and data stable until that edge. Here,
//   out_row and out_last do not change while out_valid=1 and out_ready=0.

module maxpool_frame_ctrl #(
  parameter int IMG_IN_SIZE = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IMG_IN_SIZE-1:0]   in_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IMG_IN_SIZE/2-1:0] out_row,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done
`ifdef MAXPOOL_FRAME_CNT_EN
  ,
  output logic [15:0]              frame_count
`endif
);

  localparam int IMG_OUT_SIZE = IMG_IN_SIZE / 2;
  localparam int ROW_IDX_W    = $clog2(IMG_IN_SIZE);
  // The output row index only has to span IMG_OUT_SIZE rows.
  localparam int OUT_IDX_W    = (IMG_OUT_SIZE > 1) ? $clog2(IMG_OUT_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_POOL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                                state;
  logic [ROW_IDX_W-1:0]                  in_cnt;
  logic [OUT_IDX_W-1:0]                  out_cnt;
  logic [OUT_IDX_W-1:0]                  out_cnt_nxt;
  logic                                  last_in;

  // Frame storage is kept as rows so a beat can be written with a simple
  // row index. frame_buf is the same data as a flat row-major vector:
  // row r, bit c sits at index r*IMG_IN_SIZE+c.
  logic [IMG_IN_SIZE-1:0]                frame_rows [IMG_IN_SIZE];
  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]    frame_buf;
  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]  pool_out;
  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]  pooled;
  logic [IMG_OUT_SIZE-1:0]               pooled_rows [IMG_OUT_SIZE];

  for (genvar r = 0; r < IMG_IN_SIZE; r++) begin : g_flat
    assign frame_buf[r*IMG_IN_SIZE +: IMG_IN_SIZE] = frame_rows[r];
  end

  // Combinational 2x2 binary max-pool. img_in is frame_buf and img_out is
  // pool_out. Both use the row-major layout.
  for (genvar orow = 0; orow < IMG_OUT_SIZE; orow++) begin : u_pool
    for (genvar ocol = 0; ocol < IMG_OUT_SIZE; ocol++) begin : g_col
      assign pool_out[orow*IMG_OUT_SIZE + ocol] =
          frame_buf[(2*orow)*IMG_IN_SIZE   + 2*ocol]     |
          frame_buf[(2*orow)*IMG_IN_SIZE   + 2*ocol + 1] |
          frame_buf[(2*orow+1)*IMG_IN_SIZE + 2*ocol]     |
          frame_buf[(2*orow+1)*IMG_IN_SIZE + 2*ocol + 1];
    end
  end

  for (genvar r = 0; r < IMG_OUT_SIZE; r++) begin : g_prow
    assign pooled_rows[r] = pooled[r*IMG_OUT_SIZE +: IMG_OUT_SIZE];
  end

  assign last_in     = (in_cnt == ROW_IDX_W'(IMG_IN_SIZE - 1));
  assign out_cnt_nxt = out_cnt + OUT_IDX_W'(1);

  // Both of these are pure decodes of the registered state. They change
  // only on a clock edge or on reset, just like the other outputs.
  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      pooled     <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < IMG_IN_SIZE; r++) begin
        frame_rows[r] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      if (flush) begin
        // Drop the frame. Stale buffer contents are fine because the next
        // frame overwrites every row before the next pool pass.
        state     <= S_IDLE;
        in_cnt    <= '0;
        out_cnt   <= '0;
        out_valid <= 1'b0;
        out_row   <= '0;
        out_last  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_valid) begin
              frame_rows[0] <= in_row;
              in_cnt        <= ROW_IDX_W'(1);
              state         <= S_LOAD;
            end
          end

          S_LOAD: begin
            if (in_valid) begin
              frame_rows[in_cnt] <= in_row;
              if (last_in) begin
                in_cnt <= '0;
                state  <= S_POOL;
              end else begin
                in_cnt <= in_cnt + ROW_IDX_W'(1);
              end
            end
          end

          S_POOL: begin
            // Capture the pool result. Row 0 is loaded straight into the
            // output register so it is valid in the first DRAIN cycle.
            pooled    <= pool_out;
            out_cnt   <= '0;
            out_row   <= pool_out[IMG_OUT_SIZE-1:0];
            out_last  <= (IMG_OUT_SIZE == 1);
            out_valid <= 1'b1;
            state     <= S_DRAIN;
          end

          S_DRAIN: begin
            if (out_ready) begin
              if (out_last) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                out_row    <= '0;
                out_cnt    <= '0;
                frame_done <= 1'b1;
                state      <= S_IDLE;
              end else begin
                out_cnt  <= out_cnt_nxt;
                out_row  <= pooled_rows[out_cnt_nxt];
                out_last <= (out_cnt_nxt == OUT_IDX_W'(IMG_OUT_SIZE - 1));
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MAXPOOL_FRAME_CNT_EN
  // Counts completed frames and wraps at 16 bits. Aborted frames never
  // pulse frame_done, so a flush leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_maxpool_frame_ctrl.sv
// tb_maxpool_frame_ctrl
//   Directed testbench for maxpool_frame_ctrl at IMG_IN_SIZE=28. The bench
//   keeps each frame it sends as a 2D array. It computes the expected
//   pooled rows by OR-ing each 2x2 window and queues them in exp_q. A
//   negedge compare process checks every output beat, stall stability and
//   frame_done timing against that model.

`timescale 1ns/1ps

module tb_maxpool_frame_ctrl;

  localparam int N = 28;
  localparam int M = N / 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1);
  end

  // ---------------- DUT ----------------
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_row;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_row;
  logic          out_last;
  logic          busy;
  logic          frame_done;
`ifdef MAXPOOL_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  maxpool_frame_ctrl #(.IMG_IN_SIZE(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef MAXPOOL_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [M:0]   exp_q[$];       // {last, pooled row}
  logic [N-1:0] img [N];        // frame currently being sent

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [M-1:0] pool_row(input int r);
    logic [M-1:0] v;
    v = '0;
    for (int c = 0; c < M; c++) begin
      v[c] = img[2*r][2*c] | img[2*r][2*c+1] | img[2*r+1][2*c] | img[2*r+1][2*c+1];
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  logic         fd_due = 1'b0;
  logic         new_frame = 1'b1;
  logic         prev_stall = 1'b0;
  logic [M-1:0] prev_row = '0;
  logic         prev_last = 1'b0;
  logic [M:0]   e;
  int           beats_out = 0;
  int           first_out_cyc = 0;
  int           last_out_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fd_due     = 1'b0;
      new_frame  = 1'b1;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(fd_due));
      fd_due = 1'b0;
      if (prev_stall && out_valid) begin
        check("stall_row", 32'(out_row), 32'(prev_row));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_row   = out_row;
      prev_last  = out_last;
      if (!flush && out_valid && out_ready) begin
        beats_out++;
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_row", 32'(out_row), 32'(e[M-1:0]));
          check("out_last", 32'(out_last), 32'(e[M]));
          if (new_frame) first_out_cyc = cyc;
          new_frame = e[M];
          if (e[M]) begin
            fd_due       = 1'b1;
            last_out_cyc = cyc;
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic rand_ready = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Sends rows 0..nrows-1 of img. A complete frame pushes its expected
  // pooled rows into the scoreboard.
  task automatic send_frame(input int nrows, input bit keep_valid,
                            output int t_first, output int t_last, output int wait0);
    int w;
    t_first = -1;
    t_last  = -1;
    wait0   = 0;
    for (int r = 0; r < nrows; r++) begin
      w        = 0;
      in_valid = 1'b1;
      in_row   = img[r];
      @(negedge clk);
      while (!in_ready && w < 200) begin
        w++;
        @(negedge clk);
      end
      check("row_accept", 32'(in_ready), 32'(1));
      if (r == 0) begin
        t_first = cyc;
        wait0   = w;
      end
      t_last = cyc;
      @(posedge clk);
      #1;
    end
    if (!keep_valid) in_valid = 1'b0;
    if (nrows == N) begin
      for (int r = 0; r < M; r++) exp_q.push_back({(r == M-1), pool_row(r)});
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && w < 300) begin
      w++;
      @(negedge clk);
    end
    check("drain_done", 32'(exp_q.size()), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic watch_quiet(input int ncyc, output logic ov_seen, output logic fd_seen);
    ov_seen = 1'b0;
    fd_seen = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      ov_seen |= out_valid;
      fd_seen |= frame_done;
    end
  endtask

  // ---------------- directed tests ----------------
  int   tf, tl, w0, b0, tl_prev;
  logic ov_seen, fd_seen;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_row", 32'(out_row), 32'(0));
`ifdef MAXPOOL_FRAME_CNT_EN
    check("rst_frame_count", 32'(frame_count), 32'(0));
`endif
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1: all-zero frame, out_ready held high
    for (int r = 0; r < N; r++) img[r] = '0;
    b0 = beats_out;
    send_frame(N, 1'b0, tf, tl, w0);
    wait_drain();
    check("t1_latency_first", 32'(first_out_cyc - tl), 32'(2));
    check("t1_latency_last", 32'(last_out_cyc - tl), 32'(15));
    check("t1_beats", 32'(beats_out - b0), 32'(14));

    // 2: single pixel at row 5, column 9
    for (int r = 0; r < N; r++) img[r] = '0;
    img[5][9] = 1'b1;
    check("model_row2", 32'(pool_row(2)), 32'h0010);
    check("model_row0", 32'(pool_row(0)), 32'h0000);
    send_frame(N, 1'b0, tf, tl, w0);
    wait_drain();
    check("t2_latency_first", 32'(first_out_cyc - tl), 32'(2));

    // 3: checkerboard with random back-pressure
    for (int r = 0; r < N; r++) img[r] = (r % 2 == 0) ? 28'h5555555 : 28'hAAAAAAA;
    check("model_chk_row0", 32'(pool_row(0)), 32'h3FFF);
    check("model_chk_row13", 32'(pool_row(13)), 32'h3FFF);
    b0 = beats_out;
    rand_ready = 1'b1;
    send_frame(N, 1'b0, tf, tl, w0);
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    check("t3_beats", 32'(beats_out - b0), 32'(14));

    // 4: flush after 10 rows, then a clean frame
    for (int r = 0; r < N; r++) img[r] = '1;
    send_frame(10, 1'b0, tf, tl, w0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'(0));
    check("flush_in_ready", 32'(in_ready), 32'(1));
    check("flush_out_valid", 32'(out_valid), 32'(0));
    watch_quiet(20, ov_seen, fd_seen);
    check("flush_no_out", 32'(ov_seen), 32'(0));
    check("flush_no_done", 32'(fd_seen), 32'(0));
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) img[r] = N'((r + 1) * 32'h0012_3457 ^ 32'h00A5_A5A5);
    send_frame(N, 1'b0, tf, tl, w0);
    wait_drain();
`ifdef MAXPOOL_FRAME_CNT_EN
    check("count_after_4", 32'(frame_count), 32'(4));
`endif

    // 5: asynchronous reset after 5 output beats
    for (int r = 0; r < N; r++) img[r] = N'(32'h0F0F_0F0F >> (r % 4));
    b0 = beats_out;
    send_frame(N, 1'b0, tf, tl, w0);
    for (int k = 0; k < 60 && (beats_out - b0) < 5; k++) @(posedge clk);
    check("t5_beats_before_reset", 32'(beats_out - b0), 32'(5));
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'(0));
    check("t5_rst_in_ready", 32'(in_ready), 32'(1));
    check("t5_rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    watch_quiet(20, ov_seen, fd_seen);
    check("t5_no_out", 32'(ov_seen), 32'(0));
    check("t5_no_done", 32'(fd_seen), 32'(0));
`ifdef MAXPOOL_FRAME_CNT_EN
    check("t5_count", 32'(frame_count), 32'(0));
`endif
    @(posedge clk);
    #1;

    // 6: three back-to-back frames with in_valid held high
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < N; r++) img[r] = N'((r + 1) * (f + 3) * 32'h000B_13C7);
      tl_prev = tl;
      send_frame(N, (f < 2), tf, tl, w0);
      if (f > 0) begin
        check("t6_row0_wait", 32'(w0), 32'(15));
        check("t6_row0_after_last", 32'(tf - last_out_cyc), 32'(1));
        check("t6_prev_last_beat", 32'(last_out_cyc - tl_prev), 32'(15));
      end
    end
    wait_drain();
`ifdef MAXPOOL_FRAME_CNT_EN
    check("t6_count", 32'(frame_count), 32'(3));
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
